player_sprite: RTL and testbench

//  Upstream pixel source for color_mapper. Holds the player cannon's X position and

---
 rtl/invaders_pkg.sv | 40 ++++
 rtl/player_sprite_rom.sv | 23 ++
 rtl/player_sprite.sv | 164 ++++++++++++++++
 tb/tb_player_sprite.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared constants, colours, player states and the player cannon sprite mask.
package invaders_pkg;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned PLAYER_Y   = 440;
  localparam int unsigned SPRITE_W   = 32;
  localparam int unsigned SPRITE_H   = 16;
  localparam int unsigned STEP       = 2;
  localparam int unsigned X_INIT     = 304;
  localparam int unsigned HIT_FRAMES = 60;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned XCALC_W = 11;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned COLOR_W = 24;

  localparam logic [COLOR_W-1:0] PLAYER_GREEN = 24'h20FF20;
  localparam logic [COLOR_W-1:0] EXPLODE_RED  = 24'hFF2020;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    EXPLODE = 2'd1,
    RESPAWN = 2'd2
  } player_state_t;

  // Cannon shape: 4-row barrel, 4-row turret, 8-row solid base; column 0 is the row MSB.
  function automatic logic sprite_mask_bit(input logic [ADDR_W-1:0] addr);
    logic [SPRITE_W-1:0] row_bits;
    logic [4:0]          col;
    col = addr[4:0];
    case (addr[8:5])
      4'd0, 4'd1, 4'd2, 4'd3: row_bits = 32'h0003_C000;
      4'd4, 4'd5, 4'd6, 4'd7: row_bits = 32'h0FFF_FFF0;
      default:                row_bits = 32'hFFFF_FFFF;
    endcase
    return row_bits[5'(31) - col];
  endfunction

endpackage

// File: rtl/player_sprite_rom.sv
// Synchronous 1-bit sprite mask ROM, one read per Clk.
module player_sprite_rom
  import invaders_pkg::*;
(
  input  logic              Clk,
  input  logic [ADDR_W-1:0] addr,
  output logic              mask
);

  logic mask_d;
  logic mask_q;

  always_comb begin
    mask_d = sprite_mask_bit(addr);
  end

  always_ff @(posedge Clk) begin
    mask_q <= mask_d;
  end

  assign mask = mask_q;

endmodule

// File: rtl/player_sprite.sv
// Player cannon: frame-rate movement, hit/explode/respawn FSM and a 2-stage
// pixel pipeline producing player_on / player_color for the colour mapper.
module player_sprite
  import invaders_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               hit,
  output logic               player_on,
  output logic [COLOR_W-1:0] player_color,
  output logic [COORD_W-1:0] playerX,
  output logic               player_alive
);

  logic sync1_q, sync2_q, sync3_q;
  logic frame_tick_c;

  player_state_t      state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               alive_q, alive_d;

  logic [XCALC_W-1:0] x_left_c, x_right_c;
  logic [COORD_W-1:0] x_left_clamp_c, x_right_clamp_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  logic [COORD_W-1:0] dx_c, dy_c;
  logic               in_box_c, visible_c;
  logic [ADDR_W-1:0]  rom_addr_c;
  logic               rom_mask;

  logic               in_box_s1_q, vis_s1_q;
  player_state_t      state_s1_q;
  logic               on_d, on_q;
  logic [COLOR_W-1:0] color_d, color_q;

  // frame_clk is asynchronous: two synchroniser flops plus one for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign frame_tick_c = sync2_q & ~sync3_q;

  // 11-bit arithmetic so stepping left of 0 shows up as a negative value
  always_comb begin
    x_left_c  = {1'b0, x_q} - XCALC_W'(STEP);
    x_right_c = {1'b0, x_q} + XCALC_W'(STEP);
    x_left_clamp_c  = x_left_c[XCALC_W-1] ? '0 : x_left_c[COORD_W-1:0];
    x_right_clamp_c = (x_right_c > XCALC_W'(SCREEN_W - SPRITE_W))
                      ? COORD_W'(SCREEN_W - SPRITE_W) : x_right_c[COORD_W-1:0];
    cnt_inc_c = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    case (state_q)
      ALIVE: begin
        if (hit) begin
          state_d = EXPLODE;
          cnt_d   = '0;
        end else if (frame_tick_c) begin
          if (move_left && !move_right) begin
            x_d = x_left_clamp_c;
          end else if (move_right && !move_left) begin
            x_d = x_right_clamp_c;
          end
        end
      end
      EXPLODE: begin
        if (frame_tick_c) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_W'(HIT_FRAMES)) begin
            state_d = RESPAWN;
          end
        end
      end
      RESPAWN: begin
        x_d     = COORD_W'(X_INIT);
        cnt_d   = '0;
        state_d = ALIVE;
      end
      default: state_d = ALIVE;
    endcase
    alive_d = (state_d == ALIVE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ALIVE;
      x_q     <= COORD_W'(X_INIT);
      cnt_q   <= '0;
      alive_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      alive_q <= alive_d;
    end
  end

  // Unsigned differences: pixels left of / above the sprite wrap large and fall out of the box
  always_comb begin
    dx_c       = DrawX - x_q;
    dy_c       = DrawY - COORD_W'(PLAYER_Y);
    in_box_c   = (dx_c < COORD_W'(SPRITE_W)) && (dy_c < COORD_W'(SPRITE_H));
    rom_addr_c = {dy_c[3:0], dx_c[4:0]};
    case (state_q)
      ALIVE:   visible_c = 1'b1;
      EXPLODE: visible_c = cnt_q[2];
      default: visible_c = 1'b0;
    endcase
  end

  player_sprite_rom u_rom (
    .Clk  (Clk),
    .addr (rom_addr_c),
    .mask (rom_mask)
  );

  always_comb begin
    on_d    = in_box_s1_q & rom_mask & vis_s1_q;
    color_d = '0;
    if (on_d) begin
      color_d = (state_s1_q == EXPLODE) ? EXPLODE_RED : PLAYER_GREEN;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box_s1_q <= 1'b0;
      vis_s1_q    <= 1'b0;
      state_s1_q  <= ALIVE;
      on_q        <= 1'b0;
      color_q     <= '0;
    end else begin
      in_box_s1_q <= in_box_c;
      vis_s1_q    <= visible_c;
      state_s1_q  <= state_q;
      on_q        <= on_d;
      color_q     <= color_d;
    end
  end

  assign player_on    = on_q;
  assign player_color = color_q;
  assign playerX      = x_q;
  assign player_alive = alive_q;

endmodule

// File: tb/tb_player_sprite.sv
// Directed self-checking bench for player_sprite: movement table, pixel table,
// and hand-written hit / simultaneous-input / async-reset / glitch sequences.
module tb_player_sprite;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY;
  logic        move_left, move_right, hit;
  logic        player_on;
  logic [23:0] player_color;
  logic [9:0]  playerX;
  logic        player_alive;

  int n_tests = 0;
  int n_fail  = 0;

  player_sprite dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .move_left    (move_left),
    .move_right   (move_right),
    .hit          (hit),
    .player_on    (player_on),
    .player_color (player_color),
    .playerX      (playerX),
    .player_alive (player_alive)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       ml;
    logic       mr;
    int         frames;
    logic [9:0] exp_x;
  } mv_vec_t;

  typedef struct {
    string       name;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        exp_on;
    logic [23:0] exp_color;
  } px_vec_t;

  mv_vec_t mv[8];
  px_vec_t px[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full frame_clk period; the tick lands three Clk after the rising level
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    mv[0] = '{"right_clamp",  1'b0, 1'b1, 200, 10'd608};
    mv[1] = '{"left_clamp",   1'b1, 1'b0, 400, 10'd0};
    mv[2] = '{"both_at_0",    1'b1, 1'b1, 5,   10'd0};
    mv[3] = '{"right_3",      1'b0, 1'b1, 3,   10'd6};
    mv[4] = '{"left_1",       1'b1, 1'b0, 1,   10'd4};
    mv[5] = '{"neither",      1'b0, 1'b0, 2,   10'd4};
    mv[6] = '{"both_mid",     1'b1, 1'b1, 3,   10'd4};
    mv[7] = '{"back_to_304",  1'b0, 1'b1, 150, 10'd304};

    px[0] = '{"px_310_445",   10'd310, 10'd445, 1'b1, 24'h20FF20};
    px[1] = '{"px_336_445",   10'd336, 10'd445, 1'b0, 24'h0};
    px[2] = '{"px_barrel_off",10'd304, 10'd440, 1'b0, 24'h0};
    px[3] = '{"px_barrel_on", 10'd319, 10'd440, 1'b1, 24'h20FF20};
    px[4] = '{"px_left_wrap", 10'd303, 10'd450, 1'b0, 24'h0};
    px[5] = '{"px_corner",    10'd335, 10'd455, 1'b1, 24'h20FF20};
    px[6] = '{"px_below",     10'd335, 10'd456, 1'b0, 24'h0};
    px[7] = '{"px_base",      10'd304, 10'd448, 1'b1, 24'h20FF20};

    Reset_n    = 1'b0;
    frame_clk  = 1'b0;
    DrawX      = '0;
    DrawY      = '0;
    move_left  = 1'b0;
    move_right = 1'b0;
    hit        = 1'b0;

    repeat (2) @(negedge Clk);
    check("rst_x",     32'(playerX), 32'd304);
    check("rst_alive", 32'(player_alive), 32'd1);
    check("rst_on",    32'(player_on), 32'd0);
    check("rst_color", 32'(player_color), 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      move_left  = mv[i].ml;
      move_right = mv[i].mr;
      frames(mv[i].frames);
      check(mv[i].name, 32'(playerX), 32'(mv[i].exp_x));
    end
    move_left  = 1'b0;
    move_right = 1'b0;
    check("alive_after_moves", 32'(player_alive), 32'd1);

    for (int i = 0; i < 8; i++) begin
      pixel(px[i].x, px[i].y);
      check({px[i].name, "_on"},    32'(player_on), 32'(px[i].exp_on));
      check({px[i].name, "_color"}, 32'(player_color), px[i].exp_color);
    end

    // Latency: previous pixel (304,448) is on; switch to an off pixel and watch both stages
    DrawX = 10'd336;
    DrawY = 10'd445;
    @(negedge Clk);
    check("lat_1clk_old", 32'(player_on), 32'd1);
    @(negedge Clk);
    check("lat_2clk_new", 32'(player_on), 32'd0);
    DrawX = 10'd310;
    @(negedge Clk);
    check("lat_1clk_off", 32'(player_on), 32'd0);
    @(negedge Clk);
    check("lat_2clk_on",  32'(player_on), 32'd1);

    // Hit / explode / respawn from a moved position
    move_right = 1'b1;
    frames(5);
    move_right = 1'b0;
    check("pre_hit_x", 32'(playerX), 32'd314);
    DrawX = 10'd320;
    DrawY = 10'd448;
    hit = 1'b1;
    @(negedge Clk);
    hit = 1'b0;
    check("hit_alive", 32'(player_alive), 32'd0);
    repeat (2) @(negedge Clk);
    check("expl_f0_on", 32'(player_on), 32'd0);
    move_left = 1'b1;
    frames(4);
    check("expl_f4_on",    32'(player_on), 32'd1);
    check("expl_f4_color", 32'(player_color), 32'hFF2020);
    check("expl_x_held",   32'(playerX), 32'd314);
    hit = 1'b1;
    @(negedge Clk);
    hit = 1'b0;
    frames(3);
    check("expl_f7_on", 32'(player_on), 32'd1);
    frames(1);
    check("expl_f8_off",   32'(player_on), 32'd0);
    check("expl_f8_color", 32'(player_color), 32'd0);
    move_left = 1'b0;
    frames(51);
    check("expl_f59_alive", 32'(player_alive), 32'd0);
    frames(1);
    check("respawn_alive", 32'(player_alive), 32'd1);
    check("respawn_x",     32'(playerX), 32'd304);
    check("respawn_on",    32'(player_on), 32'd1);
    check("respawn_color", 32'(player_color), 32'h20FF20);

    // Hit on the same Clk as a frame tick with move_right held
    move_right = 1'b1;
    frame_clk  = 1'b1;
    repeat (2) @(negedge Clk);
    hit = 1'b1;
    @(negedge Clk);
    hit = 1'b0;
    check("simul_x",     32'(playerX), 32'd304);
    check("simul_alive", 32'(player_alive), 32'd0);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    move_right = 1'b0;
    frames(59);
    check("simul_f59_alive", 32'(player_alive), 32'd0);
    frames(1);
    check("simul_respawn_alive", 32'(player_alive), 32'd1);
    check("simul_respawn_x",     32'(playerX), 32'd304);

    // Asynchronous reset between clock edges while the sprite is drawn
    pixel(10'd310, 10'd445);
    check("pre_rst_on", 32'(player_on), 32'd1);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check("async_on",    32'(player_on), 32'd0);
    check("async_color", 32'(player_color), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("refill_1clk", 32'(player_on), 32'd0);
    @(negedge Clk);
    check("refill_2clk", 32'(player_on), 32'd1);

    // Glitches on frame_clk with move_right held
    move_right = 1'b1;
    @(posedge Clk);
    #3 frame_clk = 1'b1;
    #3 frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    check("glitch_no_edge", 32'(playerX), 32'd304);
    @(posedge Clk);
    #8 frame_clk = 1'b1;
    #4 frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    check("glitch_one_edge", 32'(playerX), 32'd306);
    move_right = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
